perf_counter_bank: RTL and testbench

- Synthesizable, parametrised event-statistics unit that sits beside the pipelined cpu.
- Counts N single-bit per-cycle event strobes (retired instruction, I/D-cache request, I/D-cache hit, ...) plus a cycle counter.
- Freezes all counts when the processor halts and raises a timeout if no halt arrives within a cycle budget.
- Exposes counts through a registered select/read port, so hit-rate and CPI figures are available in silicon, not only in simulation.

---
 rtl/perf_pkg.sv | 27 ++
 rtl/perf_sat_counter.sv | 51 +++++
 rtl/perf_counter_bank.sv | 119 +++++++++++
 tb/tb_perf_counter_bank.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | perf_pkg : shared types and constants for the perf counter bank     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package perf_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE    = 2'd0,
    PERF_RUN     = 2'd1,
    PERF_HALTED  = 2'd2,
    PERF_TIMEOUT = 2'd3
  } perf_state_e;

  localparam int EV_RETIRE     = 0;
  localparam int EV_ICACHE_REQ = 1;
  localparam int EV_ICACHE_HIT = 2;
  localparam int EV_DCACHE_REQ = 3;
  localparam int EV_DCACHE_HIT = 4;
  localparam int EV_MEM_RD     = 5;
  localparam int EV_MEM_WR     = 6;
  localparam int EV_REG_WR     = 7;

  localparam int PERF_CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/perf_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | perf_sat_counter : saturating counter with sticky saturation flag   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (inc_i && (cnt_q != c_cnt_max)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Flag is raised as soon as the counter sits at its ceiling.
      ovf_d = ovf_q | (cnt_d == c_cnt_max);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | perf_counter_bank : event/cycle statistics with halt and timeout    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS  = 8,
  parameter int CNT_W       = perf_pkg::PERF_CNT_W,
  parameter int CYCLE_LIMIT = 100000,
  parameter int SEL_W       = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  halt_i,
  input  logic                  clear_i,
  input  logic                  rd_req_i,
  input  logic [SEL_W-1:0]      rd_sel_i,
  output logic                  rd_valid_o,
  output logic [CNT_W-1:0]      rd_data_o,
  output logic                  rd_err_o,
  output logic [NUM_EVENTS:0]   ovf_o,
  output logic [1:0]            state_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam logic [CNT_W-1:0] c_limit = CNT_W'(CYCLE_LIMIT);

  perf_state_e      state_q, state_d;
  logic             count_en;
  logic [NUM_EVENTS:0] inc;
  logic [CNT_W-1:0] cnt [NUM_EVENTS+1];
  logic [CNT_W-1:0] cycle_next;

  assign count_en   = (state_q == PERF_RUN) && en_i;
  assign inc        = {count_en, event_i & {NUM_EVENTS{count_en}}};
  assign cycle_next = cnt[NUM_EVENTS] + CNT_W'(1);

  // Index NUM_EVENTS is the cycle counter.
  for (genvar k = 0; k <= NUM_EVENTS; k++) begin : g_cnt
    perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .inc_i   (inc[k]),
      .cnt_o   (cnt[k]),
      .ovf_o   (ovf_o[k])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = PERF_IDLE;
    end else begin
      case (state_q)
        PERF_IDLE: if (en_i) state_d = PERF_RUN;
        PERF_RUN: begin
          if (en_i) begin
            if (halt_i)                      state_d = PERF_HALTED;
            else if (cycle_next == c_limit)  state_d = PERF_TIMEOUT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= PERF_IDLE;
    else     state_q <= state_d;
  end

  assign state_o   = state_q;
  assign done_o    = (state_q == PERF_HALTED) || (state_q == PERF_TIMEOUT);
  assign timeout_o = (state_q == PERF_TIMEOUT);

  logic             rd_oob;
  logic [CNT_W-1:0] rd_mux;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  assign rd_oob = rd_sel_i > SEL_W'(NUM_EVENTS);

  // Reads sample the counters before this edge's update or clear.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k <= NUM_EVENTS; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_mux = cnt[k];
    end
    rd_valid_d = rd_req_i;
    rd_err_d   = rd_req_i && rd_oob;
    rd_data_d  = rd_data_q;
    if (rd_req_i) rd_data_d = rd_oob ? '0 : rd_mux;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;
  assign rd_data_o  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_perf_counter_bank : self-checking bench with reference model     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_perf_counter_bank;

  localparam int N   = 8;
  localparam int W   = 32;
  localparam int LIM = 50;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b0, halt = 1'b0, clr = 1'b0, req = 1'b0;
  logic [7:0] ev = '0;
  logic [3:0] sel = '0;
  logic        rd_valid, rd_err, done, tmo;
  logic [31:0] rd_data;
  logic [8:0]  ovf;
  logic [1:0]  state;

  perf_counter_bank #(.NUM_EVENTS(N), .CNT_W(W), .CYCLE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .en_i(en), .event_i(ev), .halt_i(halt), .clear_i(clr),
    .rd_req_i(req), .rd_sel_i(sel), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .rd_err_o(rd_err), .ovf_o(ovf), .state_o(state), .done_o(done), .timeout_o(tmo)
  );

  // Narrow-counter instance for saturation behaviour.
  logic       s_rst = 1'b1, s_en = 1'b0, s_req = 1'b0;
  logic [7:0] s_ev = '0;
  logic [3:0] s_sel = '0;
  logic       s_valid, s_err, s_done, s_tmo;
  logic [3:0] s_data;
  logic [8:0] s_ovf;
  logic [1:0] s_state;

  perf_counter_bank #(.NUM_EVENTS(N), .CNT_W(4), .CYCLE_LIMIT(15)) dut_sat (
    .clk(clk), .rst(s_rst), .en_i(s_en), .event_i(s_ev), .halt_i(1'b0), .clear_i(1'b0),
    .rd_req_i(s_req), .rd_sel_i(s_sel), .rd_valid_o(s_valid), .rd_data_o(s_data),
    .rd_err_o(s_err), .ovf_o(s_ovf), .state_o(s_state), .done_o(s_done), .timeout_o(s_tmo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: counts as plain integers, state as an integer 0..3.
  longint unsigned m_cnt [9];
  bit [8:0]        m_ovf;
  int              m_state;
  bit              m_vld, m_err;
  longint unsigned m_data;

  task automatic m_zero();
    for (int i = 0; i < 9; i++) m_cnt[i] = 0;
    m_ovf = '0;
  endtask

  task automatic bump(input int i);
    if (m_cnt[i] < MAXV) m_cnt[i] = m_cnt[i] + 1;
    if (m_cnt[i] == MAXV) m_ovf[i] = 1'b1;
  endtask

  task automatic model_update(input bit r, input bit e, input logic [7:0] evv,
                              input bit h, input bit c, input bit q, input logic [3:0] s);
    if (r) begin
      m_zero();
      m_state = 0; m_vld = 0; m_err = 0; m_data = 0;
    end else begin
      m_vld = q;
      m_err = q && (s > 8);
      if (q) m_data = (s > 8) ? 0 : m_cnt[s];
      if (c) begin
        m_zero();
        m_state = 0;
      end else if (m_state == 0) begin
        if (e) m_state = 1;
      end else if (m_state == 1 && e) begin
        bump(8);
        for (int i = 0; i < 8; i++) if (evv[i]) bump(i);
        if (h)                m_state = 2;
        else if (m_cnt[8] == LIM) m_state = 3;
      end
    end
  endtask

  task automatic compare_all();
    check("state", state, m_state);
    check("done", done, m_state >= 2);
    check("timeout", tmo, m_state == 3);
    check("rd_valid", rd_valid, m_vld);
    check("rd_err", rd_err, m_err);
    check("rd_data", rd_data, m_data);
    check("ovf", ovf, m_ovf);
  endtask

  task automatic step(input bit r, input bit e, input logic [7:0] evv,
                      input bit h, input bit c, input bit q, input logic [3:0] s);
    rst = r; en = e; ev = evv; halt = h; clr = c; req = q; sel = s;
    @(posedge clk);
    model_update(r, e, evv, h, c, q, s);
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input bit e, input logic [7:0] evv);
    for (int i = 0; i < n; i++) step(0, e, evv, 0, 0, 0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] s);
    step(0, 0, 8'h00, 0, 0, 1, s);
  endtask

  task automatic restart();
    step(1, 0, 8'h00, 0, 0, 0, 4'd0);
    step(1, 0, 8'h00, 0, 0, 0, 4'd0);
    step(0, 1, 8'h00, 0, 0, 0, 4'd0);  // IDLE -> RUN, not counted
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] data;
    bit          err;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{4'd0,  32'd20, 1'b0};
    vt[1] = '{4'd1,  32'd0,  1'b0};
    vt[2] = '{4'd2,  32'd20, 1'b0};
    vt[3] = '{4'd5,  32'd20, 1'b0};
    vt[4] = '{4'd7,  32'd20, 1'b0};
    vt[5] = '{4'd8,  32'd20, 1'b0};
    vt[6] = '{4'd9,  32'd0,  1'b1};
    vt[7] = '{4'd15, 32'd0,  1'b1};

    // Saturation on a 4-bit instance; cycle limit 15 ends the run.
    repeat (2) @(posedge clk);
    #1;
    s_rst = 1'b0; s_en = 1'b1; s_ev = 8'h08;
    @(posedge clk); #1;
    repeat (14) begin @(posedge clk); #1; end
    check("sat_ovf_before_ceiling", s_ovf, 9'h000);
    check("sat_state_run", s_state, 2'd1);
    repeat (6) begin @(posedge clk); #1; end
    check("sat_state_timeout", s_state, 2'd3);
    check("sat_ovf_after", s_ovf, 9'h108);
    s_en = 1'b0; s_req = 1'b1; s_sel = 4'd3;
    @(posedge clk); #1;
    s_req = 1'b0;
    check("sat_ch3_read", s_data, 4'd15);
    check("sat_ch3_valid", s_valid, 1'b1);

    // Basic count
    restart();
    for (int i = 0; i < 20; i++) step(0, 1, (i % 2 == 0) ? 8'h01 : 8'h00, 0, 0, 0, 4'd0);
    rd(4'd0);
    check("basic_ch0", rd_data, 32'd10);
    check("basic_valid", rd_valid, 1'b1);
    check("basic_err", rd_err, 1'b0);
    rd(4'd8);
    check("basic_cycles", rd_data, 32'd20);
    run(1, 0, 8'h00);
    check("basic_valid_drop", rd_valid, 1'b0);
    check("basic_data_hold", rd_data, 32'd20);

    // Halt freeze
    restart();
    run(14, 1, 8'h00);
    step(0, 1, 8'h01, 1, 0, 0, 4'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'hFF, 1, 0, 0, 4'd0);
    check("halt_state", state, 2'd2);
    check("halt_done", done, 1'b1);
    rd(4'd0);
    check("halt_ch0", rd_data, 32'd1);
    rd(4'd8);
    check("halt_cycles", rd_data, 32'd15);

    // Timeout exactly at the limit
    restart();
    run(LIM - 1, 1, 8'h00);
    check("tmo_not_yet", state, 2'd1);
    run(1, 1, 8'h00);
    check("tmo_flag", tmo, 1'b1);
    step(0, 1, 8'hFF, 1, 0, 0, 4'd0);
    check("tmo_sticky", state, 2'd3);
    rd(4'd8);
    check("tmo_cycles", rd_data, 32'd50);

    // Halt on the limit cycle wins over timeout
    restart();
    run(LIM - 1, 1, 8'h00);
    step(0, 1, 8'h00, 1, 0, 0, 4'd0);
    check("tie_state", state, 2'd2);
    check("tie_timeout", tmo, 1'b0);

    // Clear returns pre-clear read data, then zero
    restart();
    run(7, 1, 8'h02);
    step(0, 1, 8'hFF, 0, 1, 1, 4'd1);
    check("clr_pre_value", rd_data, 32'd7);
    check("clr_state", state, 2'd0);
    rd(4'd1);
    check("clr_post_value", rd_data, 32'd0);

    // Reset beats clear/halt mid-run
    step(0, 1, 8'h00, 0, 0, 0, 4'd0);
    run(3, 1, 8'hFF);
    step(1, 1, 8'hFF, 1, 1, 1, 4'd2);
    check("rst_state", state, 2'd0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_data", rd_data, 32'd0);
    check("rst_ovf", ovf, 9'h000);

    // Pause excluded from counts; table of reads incl. out-of-range selects
    restart();
    run(10, 1, 8'hA5);
    run(5, 0, 8'hA5);
    run(10, 1, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      rd(vt[i].sel);
      check($sformatf("tbl_data_sel%0d", vt[i].sel), rd_data, vt[i].data);
      check($sformatf("tbl_err_sel%0d", vt[i].sel), rd_err, vt[i].err);
      check($sformatf("tbl_valid_sel%0d", vt[i].sel), rd_valid, 1'b1);
    end

    // Randomised traffic against the model
    restart();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 200) == 0, ($urandom % 8) != 0, 8'($urandom),
           ($urandom % 64) == 0, ($urandom % 40) == 0, 1'($urandom),
           4'($urandom_range(0, 12)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
